mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request front end for the 1024x32 shared memory: it buffers read/write commands from a valid/ready client, checks each command's key against the memory's key_access value, and drives one memory port with single-cycle enable pulses. Read data comes back from the memory's registered data_out and is returned on a valid/ready response channel. Commands are serviced strictly in order with one access outstanding. The error count is exported for status.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 32, data width
- KEY_W, 16, key width
- DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  FIFO can accept; equals !full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- req_key  in  KEY_W  client key
- rsp_valid  out  1  response present
- rsp_ready  in  1  client takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  key mismatch
- err_count  out  8  saturating count of rejected commands
- mem_key  in  KEY_W  memory key_access
- mem_wenable, mem_renable  out  1  one-cycle enable pulses
- mem_write_address, mem_read_address  out  ADDR_W  both driven from the command address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  registered memory read data

## Operation
- Push: on req_valid && req_ready, store {write, addr, wdata, key} in the FIFO.
- FSM states are IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: if the FIFO is non-empty, pop the head into the command register.
  - If key == mem_key (compared at pop), go to ISSUE.
  - Otherwise go to RESP with err=1 and rdata=0, and increment err_count, saturating at 255. No memory enable is asserted.
- ISSUE: assert exactly one of mem_wenable or mem_renable for one cycle.
  - Write: go to RESP with err=0 and rdata=0.
  - Read: go to WAIT.
- WAIT: capture mem_data_out into rsp_rdata at the end of the cycle, then go to RESP.
- RESP: hold rsp_valid=1 and keep rsp_rdata and rsp_err stable until rsp_ready. Return to IDLE on the handshake edge.
- Push and pop in the same cycle are legal. A push while full cannot occur.
- Addresses are used unmodified (0..1023); there is no wrap arithmetic.
- Ordering: with one access outstanding, a read issued after a write to the same address returns the written data.

## Timing
- Reset values: all outputs are 0 except req_ready=1; the FIFO is empty; the FSM is in IDLE; err_count=0.
- Reset mid-operation: the pending command and response are discarded. A write already pulsed into memory is not undone.
- Latency is measured from the acceptance edge E to rsp_valid high, with an empty FIFO and an idle FSM:
  - read: E+3
  - write: E+2
  - key error: E+1
- mem_*enable are high only during ISSUE, for exactly one cycle per accepted valid-key command.
- Back-to-back throughput with rsp_ready held at 1:
  - one read per 4 cycles
  - one write per 3 cycles
- req_ready is registered-full based and does not depend on req_valid in the same cycle.

## Structure
- Package mem_req_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - ADDR_W, DATA_W and KEY_W defaults
  - the command struct {write, addr, wdata, key}
- Sub-module req_fifo is a synchronous FIFO of the command struct with DEPTH entries. It has async reset and full/empty flags.
- The top level contains the FSM, the command register, the response register and err_count.

## Test plan
- Reset, then write addr 0x005 data 0xDEADBEEF with key=mem_key=0x0032, then read 0x005 -> rsp_valid at E+2 (write, rdata 0); the read returns 0xDEADBEEF with rsp_err=0 at E+3.
- Command with key 0x0031 and mem_key 0x0032 -> rsp_err=1, rdata 0, no mem enable pulse, err_count 0→1.
- Hold rsp_ready=0 and push 5 commands -> req_ready drops after 4 are buffered (1 in the FSM, FIFO full). Releasing rsp_ready drains all of them in order with correct data.
- Address boundary: write/read 0x3FF and 0x000 with distinct data -> each read returns its own value.
- Assert rst during WAIT of a read -> all outputs go to 0 asynchronously and req_ready=1; after release, no stale response appears.
- Send 260 bad-key commands -> err_count saturates at 255.

Source files
------------

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and default widths for the memory request front end.
//   ADDR_W_DEF/DATA_W_DEF/KEY_W_DEF : default address, data and key widths
//   state_t                         : controller FSM states
//   cmd_t                           : buffered client command
package mem_req_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int KEY_W_DEF  = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [KEY_W_DEF-1:0]  key;
    } cmd_t;

endpackage

// File: rtl/mem_req_ctrl_fifo.sv
// req_fifo: synchronous command FIFO with async reset and full/empty flags.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_data  : write strobe and command (ignored when full)
//   i_pop           : read strobe (ignored when empty)
//   o_data          : head command, valid while !o_empty
//   o_full, o_empty : registered occupancy flags
module req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // DEPTH is a power of two, so the count MSB alone marks full
    assign o_full  = r_cnt[PW];
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: key-checked, in-order request front end for a 1024x32 shared memory.
//   clk, rst                              : clock, asynchronous active-high reset
//   req_valid/req_ready                   : command handshake (req_ready = !full)
//   req_write, req_addr, req_wdata, req_key : command fields
//   rsp_valid/rsp_ready                   : response handshake
//   rsp_rdata, rsp_err                    : read data (0 for writes/errors), key mismatch flag
//   err_count                             : saturating count of rejected commands
//   mem_key                               : memory key_access value
//   mem_wenable, mem_renable              : single-cycle access pulses
//   mem_write_address, mem_read_address   : command address
//   mem_data_in, mem_data_out             : write data out, registered read data in
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [KEY_W-1:0]  req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_count,
    input  logic [KEY_W-1:0]  mem_key,
    output logic              mem_wenable,
    output logic              mem_renable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic              r_ren;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_err_count;
    cmd_t              w_in;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_in = '{write: req_write, addr: req_addr, wdata: req_wdata, key: req_key};
    assign w_pop = r_state == IDLE && !w_empty;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready         = !w_full;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rdata;
    assign rsp_err           = r_rsp_err;
    assign err_count         = r_err_count;
    assign mem_wenable       = r_wen;
    assign mem_renable       = r_ren;
    assign mem_write_address = r_addr;
    assign mem_read_address  = r_addr;
    assign mem_data_in       = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_write <= w_head.write;
                        r_addr  <= w_head.addr;
                        r_wdata <= w_head.wdata;
                        // key is judged at pop time; a rejected command never touches memory
                        if (w_head.key == mem_key) begin
                            r_state <= ISSUE;
                            r_wen   <= w_head.write;
                            r_ren   <= !w_head.write;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rdata     <= '0;
                            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    r_wen       <= 1'b0;
                    r_ren       <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rdata     <= '0;
                    r_rsp_valid <= r_write;
                    r_state     <= r_write ? RESP : WAIT;
                end
                WAIT: begin
                    // memory output register now holds the word read during ISSUE
                    r_rdata     <= mem_data_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rdata     <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed scoreboard bench with a behavioural 1024x32 memory.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [15:0] req_key = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;
    logic [15:0] mem_key = 16'h0032;
    logic        mem_wenable;
    logic        mem_renable;
    logic [9:0]  mem_write_address;
    logic [9:0]  mem_read_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_dout = '0;

    mem_req_ctrl #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_key           (req_key),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .err_count         (err_count),
        .mem_key           (mem_key),
        .mem_wenable       (mem_wenable),
        .mem_renable       (mem_renable),
        .mem_write_address (mem_write_address),
        .mem_read_address  (mem_read_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_wenable) mem[mem_write_address] <= mem_data_in;
        if (mem_renable) mem_dout <= mem[mem_read_address];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] ref_mem [1024];
    int          exp_err = 0;
    int          exp_en = 0;
    int          en_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [15:0] k);
        exp_t e;
        int   t = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_key   = k;
        while (!req_ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (k == mem_key) begin
            e.err   = 1'b0;
            e.rdata = w ? 32'd0 : ref_mem[a];
            if (w) ref_mem[a] = d;
            exp_en++;
        end else begin
            e.err   = 1'b1;
            e.rdata = 32'd0;
            if (exp_err < 255) exp_err++;
        end
        sb.push_back(e);
    endtask

    task automatic chk_lat(input string tag, input int exp);
        int k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, k, exp);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
            if (mem_wenable || mem_renable) begin
                en_cnt++;
                chk("en_single_cycle", prev_en, 0);
                chk("en_onehot", mem_wenable && mem_renable, 0);
            end
        end
        prev_en = mem_wenable || mem_renable;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {rsp_valid, rsp_err, err_count, mem_wenable, mem_renable}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", {mem_write_address, mem_read_address}, 0);
        chk("rst_wdata", mem_data_in, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(1'b1, 10'h005, 32'hDEADBEEF, 16'h0032);
        chk_lat("lat_write", 2);
        drain();
        send(1'b0, 10'h005, 32'h0, 16'h0032);
        chk_lat("lat_read", 3);
        drain();
        chk("en_count_t1", en_cnt, exp_en);

        chk("err_count_0", err_count, 0);
        send(1'b0, 10'h005, 32'h0, 16'h0031);
        chk_lat("lat_keyerr", 1);
        drain();
        chk("err_count_1", err_count, exp_err);
        chk("en_count_err", en_cnt, exp_en);

        rsp_ready = 1'b0;
        send(1'b1, 10'h010, 32'hA5A5_0010, 16'h0032);
        send(1'b0, 10'h010, 32'h0, 16'h0032);
        send(1'b1, 10'h011, 32'h5A5A_0011, 16'h0032);
        send(1'b0, 10'h011, 32'h0, 16'h0032);
        send(1'b0, 10'h005, 32'h0, 16'h0032);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_ready", req_ready, 0);
        chk("bp_hold_valid", rsp_valid, 1);
        chk("bp_hold_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        drain();
        chk("en_count_bp", en_cnt, exp_en);

        send(1'b1, 10'h3FF, 32'h1234_5678, 16'h0032);
        send(1'b1, 10'h000, 32'h9ABC_DEF0, 16'h0032);
        send(1'b0, 10'h3FF, 32'h0, 16'h0032);
        send(1'b0, 10'h000, 32'h0, 16'h0032);
        drain();

        send(1'b0, 10'h005, 32'h0, 16'h0032);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_ctrl", {rsp_valid, rsp_err, err_count, mem_wenable, mem_renable}, 0);
        chk("arst_rdata", rsp_rdata, 0);
        chk("arst_addr", {mem_write_address, mem_read_address}, 0);
        chk("arst_wdata", mem_data_in, 0);
        chk("arst_req_ready", req_ready, 1);
        sb.delete();
        exp_err = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale_rsp", rsp_valid, 0);
        end
        send(1'b0, 10'h3FF, 32'h0, 16'h0032);
        chk_lat("lat_read_after_rst", 3);
        drain();

        chk("err_count_after_rst", err_count, exp_err);
        for (int i = 0; i < 260; i++) send(1'b0, 10'h000, 32'h0, 16'h0031);
        drain();
        chk("err_sat", err_count, exp_err);
        chk("en_count_final", en_cnt, exp_en);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
